// File: rtl/nf10_flow_pkg.sv
// nf10_flow_pkg: header offsets, metadata layout and tuple builder shared by the flow extractor.
package nf10_flow_pkg;
  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [3:0] IP_VER4 = 4'd4;
  localparam logic [3:0] IHL_MIN = 4'd5;
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam int OFF_ETYPE = 12;
  localparam int OFF_VIHL = 14;
  localparam int OFF_PROTO = 23;
  localparam int OFF_SRC_IP = 26;
  localparam int OFF_DST_HI = 30;
  localparam int OFF_DST_LO = 0;
  localparam int OFF_SPORT = 2;
  localparam int OFF_DPORT = 4;
  localparam int META_W = 128;
  localparam int M_SRC_IP = 0;
  localparam int M_DST_IP = 32;
  localparam int M_SPORT = 64;
  localparam int M_DPORT = 80;
  localparam int M_PROTO = 96;
  localparam int M_LEN = 104;
  localparam int M_IS_IPV4 = 120;
  localparam int M_IHL_OK = 121;
  localparam int M_IS_TCP = 122;
  localparam int M_IS_UDP = 123;
  typedef enum logic [1:0] {S_HDR0, S_HDR1, S_BODY} state_t;
  // Non-IPv4 frames keep only length and ihl_ok; ports survive only for plain TCP/UDP headers.
  function automatic logic [META_W-1:0] build_meta(
    input logic [15:0] etype,
    input logic [7:0] vihl,
    input logic [7:0] proto,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip,
    input logic [15:0] sport,
    input logic [15:0] dport,
    input logic [15:0] len
  );
    logic ipv4, ihl_ok, tcp, udp, l4_ok;
    logic [META_W-1:0] m;
    ipv4 = etype == ETH_IPV4 && vihl[7:4] == IP_VER4;
    ihl_ok = vihl[3:0] == IHL_MIN;
    tcp = ipv4 && proto == PROTO_TCP;
    udp = ipv4 && proto == PROTO_UDP;
    l4_ok = ipv4 && ihl_ok && (tcp || udp);
    m = '0;
    m[M_SRC_IP +: 32] = ipv4 ? src_ip : 32'h0;
    m[M_DST_IP +: 32] = ipv4 ? dst_ip : 32'h0;
    m[M_SPORT +: 16] = l4_ok ? sport : 16'h0;
    m[M_DPORT +: 16] = l4_ok ? dport : 16'h0;
    m[M_PROTO +: 8] = ipv4 ? proto : 8'h0;
    m[M_LEN +: 16] = len;
    m[M_IS_IPV4] = ipv4;
    m[M_IHL_OK] = ihl_ok;
    m[M_IS_TCP] = tcp;
    m[M_IS_UDP] = udp;
    return m;
  endfunction
endpackage

// File: rtl/nf10_meta_fifo.sv
// nf10_meta_fifo: synchronous flow-tuple FIFO; output is read straight from the storage flops.
module nf10_meta_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic [WIDTH-1:0] din,
  input logic pop,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/nf10_flow_tuple_extract.sv
// nf10_flow_tuple_extract: one-cycle registered packet passthrough that emits one flow tuple per packet.
module nf10_flow_tuple_extract
  import nf10_flow_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_META_FIFO_DEPTH = 4
) (
  input logic axi_aclk,
  input logic axi_reset,
  input logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input logic [C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input logic s_axis_tvalid,
  output logic s_axis_tready,
  input logic s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic m_axis_tvalid,
  input logic m_axis_tready,
  output logic m_axis_tlast,
  output logic [META_W-1:0] m_meta_tdata,
  output logic m_meta_tvalid,
  input logic m_meta_tready,
  output logic [31:0] pkt_count
);
  localparam int NB = C_AXIS_DATA_WIDTH / 8;
  state_t state_q, state_d;
  logic [7:0] b [NB];
  logic [15:0] eth_q, dst_hi_q, len_q;
  logic [7:0] vihl_q, proto_q;
  logic [31:0] src_q;
  logic push_beat, accept, meta_push, meta_full, meta_empty;
  logic [META_W-1:0] meta_in;
  always_comb for (int i = 0; i < NB; i++) b[i] = s_axis_tdata[8*i +: 8];
  // push_beat depends on tlast but never on tvalid, so tready stays valid-independent.
  assign push_beat = state_q == S_HDR1 || (state_q == S_HDR0 && s_axis_tlast);
  assign s_axis_tready = (!m_axis_tvalid | m_axis_tready) & !(push_beat & meta_full);
  assign accept = s_axis_tvalid & s_axis_tready;
  assign meta_push = accept & push_beat;
  always_comb begin
    state_d = !accept ? state_q : s_axis_tlast ? S_HDR0 : state_q == S_HDR0 ? S_HDR1 : S_BODY;
    meta_in = state_q == S_HDR0
      ? build_meta({b[OFF_ETYPE], b[OFF_ETYPE+1]}, b[OFF_VIHL], b[OFF_PROTO],
                   {b[OFF_SRC_IP], b[OFF_SRC_IP+1], b[OFF_SRC_IP+2], b[OFF_SRC_IP+3]},
                   {b[OFF_DST_HI], b[OFF_DST_HI+1], 16'h0}, 16'h0, 16'h0, s_axis_tuser[15:0])
      : build_meta(eth_q, vihl_q, proto_q, src_q, {dst_hi_q, b[OFF_DST_LO], b[OFF_DST_LO+1]},
                   {b[OFF_SPORT], b[OFF_SPORT+1]}, {b[OFF_DPORT], b[OFF_DPORT+1]}, len_q);
  end
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      state_q <= S_HDR0;
      eth_q <= '0;
      vihl_q <= '0;
      proto_q <= '0;
      src_q <= '0;
      dst_hi_q <= '0;
      len_q <= '0;
      pkt_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == S_HDR0) begin
        eth_q <= {b[OFF_ETYPE], b[OFF_ETYPE+1]};
        vihl_q <= b[OFF_VIHL];
        proto_q <= b[OFF_PROTO];
        src_q <= {b[OFF_SRC_IP], b[OFF_SRC_IP+1], b[OFF_SRC_IP+2], b[OFF_SRC_IP+3]};
        dst_hi_q <= {b[OFF_DST_HI], b[OFF_DST_HI+1]};
        len_q <= s_axis_tuser[15:0];
      end
      if (accept && s_axis_tlast) pkt_count <= pkt_count + 32'd1;
    end
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tstrb <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata <= s_axis_tdata;
      m_axis_tstrb <= s_axis_tstrb;
      m_axis_tuser <= s_axis_tuser;
      m_axis_tlast <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  nf10_meta_fifo #(.DEPTH(C_META_FIFO_DEPTH), .WIDTH(META_W)) u_meta_fifo (
    .clk(axi_aclk),
    .rst(axi_reset),
    .push(meta_push),
    .din(meta_in),
    .pop(m_meta_tready),
    .dout(m_meta_tdata),
    .full(meta_full),
    .empty(meta_empty)
  );
  assign m_meta_tvalid = !meta_empty;
endmodule

// File: tb/tb_nf10_flow_tuple_extract.sv
// tb_nf10_flow_tuple_extract: scoreboard bench; expected beats and tuples are queued at issue and checked by a monitor.
module tb_nf10_flow_tuple_extract;
  logic clk = 1'b0;
  logic axi_reset = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0] s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic s_axis_tlast = 1'b0;
  logic [255:0] m_axis_tdata;
  logic [31:0] m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;
  logic [127:0] m_meta_tdata;
  logic m_meta_tvalid;
  logic m_meta_tready = 1'b1;
  logic [31:0] pkt_count;
  logic fix_axis = 1'b1, fix_meta = 1'b1, rand_mode = 1'b0, bp_done = 1'b0;
  int tests = 0, fails = 0, beats_sent = 0;
  logic [416:0] dq[$];
  logic [127:0] mq[$];

  nf10_flow_tuple_extract dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_meta_tdata(m_meta_tdata), .m_meta_tvalid(m_meta_tvalid), .m_meta_tready(m_meta_tready),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : fix_axis;
    m_meta_tready = rand_mode ? 1'($urandom_range(0, 1)) : fix_meta;
  end

  always @(negedge clk) begin
    logic [416:0] ed;
    logic [127:0] em;
    if (!axi_reset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        tests++;
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL data_unexpected got %h", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata});
        end else begin
          ed = dq.pop_front();
          if ({m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} !== ed) begin
            fails++;
            $display("FAIL data got %h want %h", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, ed);
          end
        end
      end
      if (m_meta_tvalid && m_meta_tready) begin
        tests++;
        if (mq.size() == 0) begin
          fails++;
          $display("FAIL meta_unexpected got %h", m_meta_tdata);
        end else begin
          em = mq.pop_front();
          if (m_meta_tdata !== em) begin
            fails++;
            $display("FAIL meta got %h want %h", m_meta_tdata, em);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [127:0] exp_meta(input logic [15:0] et, input logic [7:0] vihl,
      input logic [7:0] pr, input logic [31:0] src, input logic [31:0] dst,
      input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len, input int nb);
    logic v4, ok, t, u, ports;
    logic [31:0] d;
    v4 = (et == 16'h0800) && (vihl[7:4] == 4'h4);
    ok = vihl[3:0] == 4'h5;
    t = v4 && pr == 8'd6;
    u = v4 && pr == 8'd17;
    ports = v4 && ok && (t || u) && nb > 1;
    d = nb > 1 ? dst : {dst[31:16], 16'h0};
    return {4'h0, u, t, ok, v4, len, v4 ? pr : 8'h0, ports ? dp : 16'h0, ports ? sp : 16'h0,
            v4 ? d : 32'h0, v4 ? src : 32'h0};
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
    int n = 0;
    s_axis_tdata = d;
    s_axis_tstrb = s;
    s_axis_tuser = u;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    dq.push_back({l, u, s, d});
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      if (++n > 1000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout beat %0d", beats_sent);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    beats_sent++;
  endtask

  task automatic send_pkt(input logic [15:0] et, input logic [7:0] vihl, input logic [7:0] pr,
      input logic [31:0] src, input logic [31:0] dst, input logic [15:0] sp, input logic [15:0] dp,
      input logic [15:0] len, input int nb, input int nsend, input logic [127:0] expm);
    logic [7:0] p [160];
    logic [255:0] d;
    logic [127:0] u;
    for (int i = 0; i < 160; i++) p[i] = 8'($urandom);
    {p[12], p[13]} = et;
    p[14] = vihl;
    p[23] = pr;
    {p[26], p[27], p[28], p[29]} = src;
    {p[30], p[31], p[32], p[33]} = dst;
    {p[34], p[35]} = sp;
    {p[36], p[37]} = dp;
    u = {$urandom, $urandom, $urandom, 16'($urandom), len};
    mq.push_back(expm);
    for (int bt = 0; bt < nsend; bt++) begin
      for (int i = 0; i < 32; i++) d[8*i +: 8] = p[32*bt + i];
      send_beat(d, bt == nb - 1 ? 32'h0000_FFFF : 32'hFFFF_FFFF, u, bt == nb - 1);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && (dq.size() != 0 || mq.size() != 0); k++) @(posedge clk);
    chk("drain_left", 256'(dq.size() + mq.size()), 256'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dq.delete();
    mq.delete();
    axi_reset = 1'b0;
  endtask

  initial begin
    logic [15:0] et;
    logic [7:0] vihl, pr;
    logic [31:0] src, dst;
    logic [15:0] sp, dp, len;
    int nb;
    #2;
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
    chk("rst_tdata", m_axis_tdata, 256'd0);
    chk("rst_tuser_tstrb_tlast", 256'({m_axis_tuser, m_axis_tstrb, m_axis_tlast}), 256'd0);
    chk("rst_meta_valid", 256'(m_meta_tvalid), 256'd0);
    chk("rst_meta_data", 256'(m_meta_tdata), 256'd0);
    chk("rst_pkt_count", 256'(pkt_count), 256'd0);
    do_reset();
    // ARP runt: only length survives, byte 14 is 0 so ihl_ok is clear too.
    send_pkt(16'h0806, 8'h00, 8'h11, 32'h0A000001, 32'h0A000002, 16'd1, 16'd2, 16'd32, 1, 1,
             {8'h00, 16'd32, 104'h0});
    drain();
    chk("runt_pkt_count", 256'(pkt_count), 256'd1);
    send_pkt(16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 16'd64, 2, 2,
             {4'h0, 4'b0111, 16'd64, 8'd6, 16'h0050, 16'h04D2, 32'h0A000002, 32'h0A000001});
    send_pkt(16'h0800, 8'h46, 8'd17, 32'hC0A80001, 32'hC0A80002, 16'd53, 16'd5353, 16'd100, 4, 4,
             {4'h0, 4'b1001, 16'd100, 8'd17, 32'h0, 32'hC0A80002, 32'hC0A80001});
    drain();
    chk("pkt_count_3", 256'(pkt_count), 256'd3);
    // Metadata backpressure: four tuples fill the FIFO, the fifth packet stalls on its second beat.
    fix_meta = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    beats_sent = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_pkt(16'h0800, 8'h45, 8'd6, 32'h01020300 + 32'(i), 32'h05060708, 16'(1000 + i), 16'd443,
                   16'(40 + i), 2, 2,
                   exp_meta(16'h0800, 8'h45, 8'd6, 32'h01020300 + 32'(i), 32'h05060708, 16'(1000 + i),
                            16'd443, 16'(40 + i), 2));
        bp_done = 1'b1;
      end
    join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("bp_tready_low", 256'(s_axis_tready), 256'd0);
    chk("bp_beats_accepted", 256'(beats_sent), 256'd9);
    chk("bp_meta_valid", 256'(m_meta_tvalid), 256'd1);
    chk("bp_data_idle", 256'(m_axis_tvalid), 256'd0);
    fix_meta = 1'b1;
    for (int k = 0; k < 500 && !bp_done; k++) @(posedge clk);
    chk("bp_sender_done", 256'(bp_done), 256'd1);
    drain();
    chk("pkt_count_9", 256'(pkt_count), 256'd9);
    // Reset while a body beat is stalled in the output register.
    send_pkt(16'h0800, 8'h45, 8'd6, 32'h0B000001, 32'h0B000002, 16'd7, 16'd8, 16'd160, 5, 3,
             exp_meta(16'h0800, 8'h45, 8'd6, 32'h0B000001, 32'h0B000002, 16'd7, 16'd8, 16'd160, 5));
    #2;
    fix_axis = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    send_beat({8{32'hDEADBEEF}}, 32'hFFFF_FFFF, 128'h1, 1'b0);
    #2;
    chk("pre_rst_tvalid", 256'(m_axis_tvalid), 256'd1);
    axi_reset = 1'b1;
    #1;
    chk("midrst_tvalid", 256'(m_axis_tvalid), 256'd0);
    chk("midrst_tdata", m_axis_tdata, 256'd0);
    chk("midrst_tuser", 256'(m_axis_tuser), 256'd0);
    chk("midrst_pkt_count", 256'(pkt_count), 256'd0);
    chk("midrst_meta", 256'({m_meta_tvalid, m_meta_tdata}), 256'd0);
    @(posedge clk);
    #1;
    dq.delete();
    mq.delete();
    axi_reset = 1'b0;
    fix_axis = 1'b1;
    send_pkt(16'h0800, 8'h45, 8'd17, 32'hAC100001, 32'hAC100002, 16'd4000, 16'd53, 16'd90, 3, 3,
             exp_meta(16'h0800, 8'h45, 8'd17, 32'hAC100001, 32'hAC100002, 16'd4000, 16'd53, 16'd90, 3));
    drain();
    chk("post_rst_pkt_count", 256'(pkt_count), 256'd1);
    // 100 mixed packets under random tready on both outputs.
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 100; n++) begin
      et = (n % 4 == 2) ? 16'h0806 : 16'h0800;
      vihl = (n % 7 == 0) ? 8'h65 : (n % 5 == 0) ? 8'h46 : 8'h45;
      pr = (n % 4 == 0) ? 8'd6 : (n % 4 == 1) ? 8'd17 : (n % 4 == 3) ? 8'd1 : 8'($urandom);
      src = $urandom;
      dst = $urandom;
      sp = 16'($urandom);
      dp = 16'($urandom);
      nb = 1 + $urandom_range(0, 3);
      len = 16'(nb * 32 - 16);
      send_pkt(et, vihl, pr, src, dst, sp, dp, len, nb, nb, exp_meta(et, vihl, pr, src, dst, sp, dp, len, nb));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    drain();
    chk("rand_pkt_count", 256'(pkt_count), 256'd100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nf10_flow_tuple_extract.md
# nf10_flow_tuple_extract

Downstream of `nf10_packet_decoder` on each decoded port: consumes one 256-bit AXI4-Stream packet stream and forwards it unchanged with one cycle of registered latency. In parallel, it parses the Ethernet, IPv4 and L4 headers and emits one 128-bit flow-metadata word per packet on a separate stream. The Snort rule-match stage uses that word for port and protocol prefiltering.

## Interface
- `C_AXIS_DATA_WIDTH`, 256: data width. Only 256 is supported.
- `C_AXIS_TUSER_WIDTH`, 128: tuser width. Bits [15:0] carry the byte length.
- `C_META_FIFO_DEPTH`, 4: metadata FIFO entries. Must be a power of 2, ≥2.
- `axi_aclk`  in  1  sole clock.
- `axi_reset`  in  1  reset. Asynchronous assert, active-high.
- `s_axis_tdata / tstrb / tuser / tvalid / tready / tlast`  in/in/in/in/out/in  256/32/128/1/1/1  packet input.
- `m_axis_tdata / tstrb / tuser / tvalid / tready / tlast`  out/out/out/out/in/out  256/32/128/1/1/1  packet output.
- `m_meta_tdata`  out  128  flow tuple.
- `m_meta_tvalid`  out  1  flow tuple valid.
- `m_meta_tready`  in  1  flow tuple accepted.
- `pkt_count`  out  32  packets completed since reset. Wraps at 2^32.

## Operation
- Byte i of a beat is `tdata[8i+7:8i]`. Multi-byte fields are assembled big-endian from the wire.
- FSM states: `S_HDR0`, `S_HDR1`, `S_BODY`.
  - `S_HDR0`: captures the beat-0 bytes. Ethertype is bytes 12–13. IP ver/IHL is byte 14. Proto is byte 23. Source IP is bytes 26–29. Destination IP bytes 30–31 are held for beat 1.
  - On a beat-0 accept with tlast=0 → `S_HDR1`.
  - On a beat-0 accept with tlast=1 → metadata is emitted with all beat-1 fields = 0, and the FSM stays in `S_HDR0`.
- `S_HDR1`: reads beat bytes 0–1 (packet bytes 32–33, completing the destination IP). Reads L4 source port at beat bytes 2–3 and destination port at beat bytes 4–5.
  - On accept, metadata is pushed.
  - tlast=1 → `S_HDR0`, else → `S_BODY`.
- `S_BODY`: passthrough only. Accepting a tlast beat → `S_HDR0`.
- Metadata word layout:
  - [31:0] source IP
  - [63:32] destination IP
  - [79:64] source port
  - [95:80] destination port
  - [103:96] proto
  - [119:104] tuser[15:0] length
  - [120] is_ipv4: ethertype 0x0800 and version 4
  - [121] ihl_ok: IHL == 5
  - [122] is_tcp: is_ipv4, proto 6
  - [123] is_udp: is_ipv4, proto 17
  - [127:124] = 0
- Ports are forced to 0 unless is_ipv4 and ihl_ok and (tcp or udp). IP and proto fields are forced to 0 unless is_ipv4.
- `pkt_count` increments on each accepted tlast beat.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_meta_tvalid` = 0.
  - `m_axis_tdata`, `tstrb`, `tuser`, `tlast` = 0.
  - `m_meta_tdata` = 0; `pkt_count` = 0.
  - FSM in `S_HDR0`; FIFO empty.
- Data path is a single output register, so latency is 1 cycle.
- `s_axis_tready` = (!m_axis_tvalid | m_axis_tready) & !(push_beat & meta_full).
  - push_beat is the beat that would push metadata: `S_HDR1`, or `S_HDR0` with tlast.
  - `s_axis_tready` must not depend on `s_axis_tvalid`.
- Throughput: one beat per cycle when downstream is ready and the FIFO is not full.
- Metadata appears on `m_meta_tvalid` the cycle after its push when the FIFO was empty (FIFO registered output).
- `m_meta_tdata` is stable while valid and not ready.
- Simultaneous FIFO push and pop when full: the push is stalled (full check uses the current count). Push and pop when non-full both occur.
- Backpressure on one output never drops data on the other.
- Reset mid-packet: all state is cleared. The partial packet's tail is then parsed as a new packet. Upstream must reset together with this block.

## Structure
- Package `nf10_flow_pkg`:
  - ethertype constant 0x0800
  - proto constants 6 and 17
  - byte offsets
  - metadata bit-field positions
  - FSM state enum
- Sub-module `nf10_meta_fifo`:
  - Synchronous FIFO, 128 bits wide, depth `C_META_FIFO_DEPTH`.
  - Provides full, empty and registered output.
  - Same clock and reset.

## Test plan
- 2-beat IPv4/TCP packet:
  - Stimulus: 10.0.0.1 → 10.0.0.2, ports 1234 → 80, length 64.
  - Response: meta = src 0x0A000001, dst 0x0A000002, sport 0x04D2, dport 0x0050, proto 6, len 64, flags 0b0111. Data is bit-exact at 1-cycle latency.
- 1-beat runt, ethertype 0x0806:
  - Response: meta shows is_ipv4=0 with IP, port and proto fields 0. `pkt_count` = 1.
- IPv4/UDP packet with IHL=6:
  - Response: proto 17, is_udp=1, ihl_ok=0, ports 0.
- Metadata backpressure:
  - Stimulus: `m_meta_tready` = 0, send 6 packets.
  - Response: after 4 metadata pushes, `s_axis_tready` drops on the 5th packet's push_beat. Releasing ready drains all 6 tuples in order with no data-path loss.
- Random tready on both outputs, 100 mixed packets:
  - Response: scoreboard matches data and tuples; `pkt_count` = 100.
- Reset asserted mid-`S_BODY`:
  - Response: outputs go to 0 immediately. The next packet parses correctly.
